// File: rtl/kbd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | kbd_pkg : shared types and constants for the 4x4 keypad scanner     |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
package kbd_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } kbd_state_t;

  localparam int         ROWS      = 4;
  localparam int         COLS      = 4;
  localparam logic [3:0] ROW_RESET = 4'b1110;

  // Lowest-index low column wins when several columns read low together.
  function automatic logic [1:0] first_low(input logic [COLS-1:0] v);
    logic [1:0] idx;
    idx = 2'd3;
    if (!v[0])      idx = 2'd0;
    else if (!v[1]) idx = 2'd1;
    else if (!v[2]) idx = 2'd2;
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | key_sync : 2-flop synchronizer, reset to all-ones (idle keypad)     |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
module key_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '1;
      o_sync <= '1;
    end else begin
      r_meta <= i_async;
      o_sync <= r_meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | keypad_scanner : 4x4 matrix keypad scan with press/release debounce |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
module keypad_scanner
  import kbd_pkg::*;
#(
  parameter int N        = 16,
  parameter int DB_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int             c_DB_W    = $clog2(DB_TICKS) + 1;
  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DB_TICKS - 1);

  logic [3:0]        w_col_s;
  logic [N-1:0]      r_tick_cnt;
  logic              w_tick;
  logic              w_col_hit;
  logic              w_col_bit;
  logic              w_db_done;
  logic [c_DB_W-1:0] w_db_inc;

  kbd_state_t        r_state,     w_state_nxt;
  logic [3:0]        r_row_out,   w_row_out_nxt;
  logic [1:0]        r_row_idx,   w_row_idx_nxt;
  logic [1:0]        r_col_idx,   w_col_idx_nxt;
  logic [c_DB_W-1:0] r_db_cnt,    w_db_cnt_nxt;
  logic [3:0]        r_key_code,  w_key_code_nxt;
  logic              r_key_valid, w_key_valid_nxt;
  logic              r_key_held,  w_key_held_nxt;

  key_sync #(.WIDTH(COLS)) u_col_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (col_in),
    .o_sync  (w_col_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tick_cnt <= '0;
    else     r_tick_cnt <= r_tick_cnt + N'(1);
  end

  assign w_tick    = &r_tick_cnt;
  assign w_col_hit = ~&w_col_s;
  assign w_col_bit = w_col_s[r_col_idx];
  assign w_db_done = (r_db_cnt == c_DB_LAST);
  // Saturating increment so the counter can never wrap back into range.
  assign w_db_inc  = (&r_db_cnt) ? r_db_cnt : r_db_cnt + c_DB_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SCAN;
      r_row_out   <= ROW_RESET;
      r_row_idx   <= 2'd0;
      r_col_idx   <= 2'd0;
      r_db_cnt    <= '0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_row_out   <= w_row_out_nxt;
      r_row_idx   <= w_row_idx_nxt;
      r_col_idx   <= w_col_idx_nxt;
      r_db_cnt    <= w_db_cnt_nxt;
      r_key_code  <= w_key_code_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_key_held  <= w_key_held_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_row_out_nxt   = r_row_out;
    w_row_idx_nxt   = r_row_idx;
    w_col_idx_nxt   = r_col_idx;
    w_db_cnt_nxt    = r_db_cnt;
    w_key_code_nxt  = r_key_code;
    w_key_valid_nxt = 1'b0;
    w_key_held_nxt  = r_key_held;

    if (w_tick) begin
      case (r_state)
        SCAN: begin
          if (w_col_hit) begin
            w_col_idx_nxt = first_low(w_col_s);
            w_db_cnt_nxt  = '0;
            w_state_nxt   = DEBOUNCE;
          end else begin
            w_row_out_nxt = {r_row_out[2:0], r_row_out[3]};
            w_row_idx_nxt = r_row_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (!w_col_bit) begin
            if (w_db_done) begin
              w_key_code_nxt  = {r_row_idx, r_col_idx};
              w_key_valid_nxt = 1'b1;
              w_key_held_nxt  = 1'b1;
              w_state_nxt     = PRESSED;
            end else begin
              w_db_cnt_nxt = w_db_inc;
            end
          end else begin
            // Bounce: drop back to scanning; the row advances on a later tick.
            w_state_nxt = SCAN;
          end
        end
        PRESSED: begin
          if (w_col_bit) begin
            w_db_cnt_nxt = '0;
            w_state_nxt  = RELEASE;
          end
        end
        RELEASE: begin
          if (w_col_bit) begin
            if (w_db_done) begin
              w_key_held_nxt = 1'b0;
              w_row_out_nxt  = {r_row_out[2:0], r_row_out[3]};
              w_row_idx_nxt  = r_row_idx + 2'd1;
              w_state_nxt    = SCAN;
            end else begin
              w_db_cnt_nxt = w_db_inc;
            end
          end else begin
            w_state_nxt = PRESSED;
          end
        end
        default: w_state_nxt = SCAN;
      endcase
    end
  end

  assign row_out   = r_row_out;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule
`default_nettype wire
